// File: rtl/conv_cop_pkg.sv
// Shared register map, bit positions, AXI response codes and FSM state types
// for the ConvolutionCop AXI4-Lite register file.
package conv_cop_pkg;

    localparam int unsigned REG_CTRL       = 0;
    localparam int unsigned REG_STATUS     = 1;
    localparam int unsigned REG_FIRST_COEF = 2;

    localparam int unsigned CTRL_START_BIT    = 0;
    localparam int unsigned CTRL_SOFT_CLR_BIT = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT   = 2;

    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/conv_cop_axil_rd.sv
// AXI4-Lite read channel: one outstanding read, registered rdata/rresp,
// out-of-range indices return zero with SLVERR.
module conv_cop_axil_rd
    import conv_cop_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [IDX_W-1:0]           ar_idx,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [DATA_W-1:0]          rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready,
    input  logic [NUM_REGS*DATA_W-1:0] rd_view
);

    localparam int unsigned SEL_W = IDX_W - 1;

    rd_state_t         state_q, state_d;
    logic              arready_d, rvalid_d, in_range_c;
    logic [DATA_W-1:0] rdata_d, mux_c;
    logic [1:0]        rresp_d;
    logic [DATA_W-1:0] view_a [NUM_REGS];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_view
        assign view_a[i] = rd_view[i*DATA_W +: DATA_W];
    end

    always_comb begin
        in_range_c = (ar_idx < IDX_W'(NUM_REGS));
        mux_c      = in_range_c ? view_a[ar_idx[SEL_W-1:0]] : '0;
    end

    always_comb begin
        state_d   = state_q;
        arready_d = arready;
        rvalid_d  = rvalid;
        rdata_d   = rdata;
        rresp_d   = rresp;
        case (state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready) begin
                    state_d   = R_DATA;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = mux_c;
                    rresp_d   = in_range_c ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: begin
                if (rready) begin
                    state_d   = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            arready <= arready_d;
            rvalid  <= rvalid_d;
            rdata   <= rdata_d;
            rresp   <= rresp_d;
        end
    end

endmodule

// File: rtl/conv_cop_axil_regfile.sv
// ConvolutionCop AXI4-Lite register file: CTRL/STATUS pair plus coefficient bank
// exported to the core. Optional irq output and CTRL.IRQ_EN under CONV_COP_IRQ_EN.
module conv_cop_axil_regfile
    import conv_cop_pkg::*;
#(
    parameter  int unsigned DATA_W   = 32,
    parameter  int unsigned NUM_REGS = 8,
    // One extra index bit so accesses just past the bank decode as SLVERR.
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS) + $clog2(DATA_W/8) + 1
) (
    input  logic                                s00_axi_aclk,
    input  logic                                s00_axi_aresetn,
    input  logic [ADDR_W-1:0]                   s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [DATA_W-1:0]                   s00_axi_wdata,
    input  logic [DATA_W/8-1:0]                 s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [ADDR_W-1:0]                   s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [DATA_W-1:0]                   s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
`ifdef CONV_COP_IRQ_EN
    output logic                                irq,
`endif
    output logic                                core_start,
    input  logic                                core_busy,
    input  logic                                core_done,
    output logic [(NUM_REGS-2)*DATA_W-1:0]      core_regs
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = ADDR_W - LSB;
    localparam int unsigned NCOEF  = NUM_REGS - REG_FIRST_COEF;

    wr_state_t             wr_state_q, wr_state_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d, wmask_c;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  awready_d, wready_d, bvalid_d;
    logic [1:0]            bresp_d;
    logic                  commit_c, wr_ctrl_c, wr_status_c;
    logic                  soft_clr_q, done_q;
    logic [DATA_W-1:0]     ctrl_view_c, status_view_c;
    logic [NUM_REGS*DATA_W-1:0] rd_view;
    logic                  unused_bits;

    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[LSB-1:0], s00_axi_araddr[LSB-1:0]};

    // A write commits on the cycle both address and data are held.
    assign commit_c    = (wr_state_q == W_IDLE) && aw_held_q && w_held_q;
    assign wr_ctrl_c   = commit_c && (aw_idx_q == IDX_W'(REG_CTRL)) && wstrb_q[0];
    assign wr_status_c = commit_c && (aw_idx_q == IDX_W'(REG_STATUS)) && wstrb_q[0];

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        awready_d  = s00_axi_awready;
        wready_d   = s00_axi_wready;
        bvalid_d   = s00_axi_bvalid;
        bresp_d    = s00_axi_bresp;
        case (wr_state_q)
            W_IDLE: begin
                if (s00_axi_awvalid && s00_axi_awready) begin
                    aw_held_d = 1'b1;
                    aw_idx_d  = s00_axi_awaddr[ADDR_W-1:LSB];
                end
                if (s00_axi_wvalid && s00_axi_wready) begin
                    w_held_d = 1'b1;
                    wdata_d  = s00_axi_wdata;
                    wstrb_d  = s00_axi_wstrb;
                end
                awready_d = !aw_held_d;
                wready_d  = !w_held_d;
                if (commit_c) begin
                    wr_state_d = W_RESP;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    awready_d  = 1'b0;
                    wready_d   = 1'b0;
                    bvalid_d   = 1'b1;
                    bresp_d    = (aw_idx_q < IDX_W'(NUM_REGS)) ? RESP_OKAY : RESP_SLVERR;
                end
            end
            W_RESP: begin
                awready_d = 1'b0;
                wready_d  = 1'b0;
                if (s00_axi_bvalid && s00_axi_bready) begin
                    wr_state_d = W_IDLE;
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            wr_state_q      <= W_IDLE;
            aw_held_q       <= 1'b0;
            w_held_q        <= 1'b0;
            aw_idx_q        <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_bresp   <= RESP_OKAY;
            core_start      <= 1'b0;
            soft_clr_q      <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            wr_state_q      <= wr_state_d;
            aw_held_q       <= aw_held_d;
            w_held_q        <= w_held_d;
            aw_idx_q        <= aw_idx_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
            s00_axi_awready <= awready_d;
            s00_axi_wready  <= wready_d;
            s00_axi_bvalid  <= bvalid_d;
            s00_axi_bresp   <= bresp_d;
            core_start      <= wr_ctrl_c && wdata_q[CTRL_START_BIT];
            soft_clr_q      <= wr_ctrl_c && wdata_q[CTRL_SOFT_CLR_BIT];
            // A same-cycle core_done beats both the W1C and the soft clear.
            done_q          <= core_done ||
                               (done_q && !(wr_status_c && wdata_q[STATUS_DONE_BIT])
                                       && !soft_clr_q);
        end
    end

`ifdef CONV_COP_IRQ_EN
    logic irq_en_q;

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            irq_en_q <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_ctrl_c) begin
                irq_en_q <= wdata_q[CTRL_IRQ_EN_BIT];
            end
            irq <= done_q && irq_en_q;
        end
    end

    always_comb begin
        ctrl_view_c                  = '0;
        ctrl_view_c[CTRL_IRQ_EN_BIT] = irq_en_q;
    end
`else
    assign ctrl_view_c = '0;
`endif

    always_comb begin
        status_view_c                  = '0;
        status_view_c[STATUS_BUSY_BIT] = core_busy;
        status_view_c[STATUS_DONE_BIT] = done_q;
    end

    assign rd_view[REG_CTRL*DATA_W +: DATA_W]   = ctrl_view_c;
    assign rd_view[REG_STATUS*DATA_W +: DATA_W] = status_view_c;

    for (genvar b = 0; b < STRB_W; b++) begin : g_mask
        assign wmask_c[8*b +: 8] = {8{wstrb_q[b]}};
    end

    // Coefficient bank; soft clear wins over a same-cycle write.
    for (genvar r = 0; r < NCOEF; r++) begin : g_coef
        logic [DATA_W-1:0] coef_q;

        always_ff @(posedge s00_axi_aclk) begin
            if (!s00_axi_aresetn || soft_clr_q) begin
                coef_q <= '0;
            end else if (commit_c && (aw_idx_q == IDX_W'(r + REG_FIRST_COEF))) begin
                coef_q <= (coef_q & ~wmask_c) | (wdata_q & wmask_c);
            end
        end

        assign core_regs[r*DATA_W +: DATA_W]                    = coef_q;
        assign rd_view[(r+REG_FIRST_COEF)*DATA_W +: DATA_W]     = coef_q;
    end

    conv_cop_axil_rd #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_rd (
        .clk     (s00_axi_aclk),
        .rst_n   (s00_axi_aresetn),
        .ar_idx  (s00_axi_araddr[ADDR_W-1:LSB]),
        .arvalid (s00_axi_arvalid),
        .arready (s00_axi_arready),
        .rdata   (s00_axi_rdata),
        .rresp   (s00_axi_rresp),
        .rvalid  (s00_axi_rvalid),
        .rready  (s00_axi_rready),
        .rd_view (rd_view)
    );

endmodule

// File: tb/tb_conv_cop_axil_regfile.sv
// Directed self-checking bench for conv_cop_axil_regfile (DATA_W=32, NUM_REGS=8).
module tb_conv_cop_axil_regfile;

    localparam int ADDR_W = 6;
    localparam int CR_W   = 6 * 32;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [2:0]        awprot, arprot;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [31:0]       wdata, rdata;
    logic [3:0]        wstrb;
    logic [1:0]        bresp, rresp;
    logic              core_start, core_busy, core_done;
    logic [CR_W-1:0]   core_regs;
`ifdef CONV_COP_IRQ_EN
    logic              irq;
`endif

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (core_start) start_cnt++;

    conv_cop_axil_regfile dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
`ifdef CONV_COP_IRQ_EN
        .irq             (irq),
`endif
        .core_start      (core_start),
        .core_busy       (core_busy),
        .core_done       (core_done),
        .core_regs       (core_regs)
    );

    task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int   n = 0;
        logic aw_hs, w_hs;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while ((awvalid || wvalid) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(negedge clk); n++;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
        end
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        resp = bresp;
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL write_timeout addr=%h got no bvalid, required bvalid within 20 cycles", addr);
            awvalid = 1'b0; wvalid = 1'b0;
        end
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        data = rdata; resp = rresp;
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL read_timeout addr=%h got no rvalid, required rvalid within 20 cycles", addr);
        end
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        core_busy = 1'b0; core_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, core_start} !== 6'b0) begin
            errors++;
            $display("FAIL reset_hs got aw/w/ar/b/r/start=%b required 000000",
                     {awready, wready, arready, bvalid, rvalid, core_start});
        end
        checks++;
        if ({rdata, rresp, bresp} !== 36'h0) begin
            errors++;
            $display("FAIL reset_data got rdata=%h rresp=%b bresp=%b required 0", rdata, rresp, bresp);
        end
        checks++;
        if (core_regs !== '0) begin
            errors++; $display("FAIL reset_core_regs got %h required 0", core_regs);
        end
        aresetn = 1'b1;
        @(negedge clk);
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready got %b required 111", {awready, wready, arready});
        end
    endtask

    task automatic test_seq_rw();
        logic [1:0]  resp;
        logic [31:0] d;
        for (int i = 2; i < 8; i++) begin
            axi_write(ADDR_W'(i * 4), 32'(i - 1), 4'hF, resp);
            checks++;
            if (resp !== 2'b00) begin
                errors++; $display("FAIL seq_bresp reg=%0d got %b required 00", i, resp);
            end
        end
        for (int i = 2; i < 8; i++) begin
            axi_read(ADDR_W'(i * 4), d, resp);
            checks++;
            if (d !== 32'(i - 1) || resp !== 2'b00) begin
                errors++;
                $display("FAIL seq_read reg=%0d got %h/%b required %h/00", i, d, resp, 32'(i - 1));
            end
        end
        checks++;
        if (core_regs !== {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}) begin
            errors++; $display("FAIL seq_core_regs got %h", core_regs);
        end
    endtask

    task automatic test_strobe();
        logic [1:0]  resp;
        logic [31:0] d;
        axi_write(6'h0C, 32'hAABBCCDD, 4'hF, resp);
        axi_write(6'h0C, 32'h11223344, 4'b0101, resp);
        axi_read(6'h0C, d, resp);
        checks++;
        if (d !== 32'hAA22CC44) begin
            errors++; $display("FAIL strobe_merge got %h required aa22cc44", d);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0]  resp;
        logic [31:0] d;
        @(negedge clk);
        wdata = 32'h5A5A0F0F; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        checks++;
        if (wready !== 1'b1) begin errors++; $display("FAIL wfirst_wready got %b required 1", wready); end
        @(negedge clk);
        wvalid = 1'b0;
        checks++;
        if ({wready, awready} !== 2'b01) begin
            errors++; $display("FAIL wfirst_held got w/aw ready=%b required 01", {wready, awready});
        end
        @(negedge clk);
        @(negedge clk);
        awaddr = 6'h10; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({bvalid, awready, wready} !== 3'b100) begin
                errors++;
                $display("FAIL wfirst_bhold k=%0d got b/aw/w=%b required 100", k, {bvalid, awready, wready});
            end
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        checks++;
        if ({bvalid, awready} !== 2'b01) begin
            errors++; $display("FAIL wfirst_bdone got b/aw=%b required 01", {bvalid, awready});
        end
        axi_read(6'h10, d, resp);
        checks++;
        if (d !== 32'h5A5A0F0F) begin errors++; $display("FAIL wfirst_data got %h required 5a5a0f0f", d); end
        axi_read(6'h14, d, resp);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL wfirst_neighbour got %h required 4", d); end
    endtask

    task automatic test_ctrl_status();
        logic [1:0]  resp;
        logic [31:0] d;
        start_cnt = 0;
        axi_write(6'h00, 32'h1, 4'hF, resp);
        repeat (2) @(negedge clk);
        checks++;
        if (start_cnt !== 1) begin errors++; $display("FAIL start_pulse got %0d cycles required 1", start_cnt); end
        axi_read(6'h00, d, resp);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL ctrl_read got %h required 0", d); end
        @(negedge clk); core_done = 1'b1;
        @(negedge clk); core_done = 1'b0;
        axi_read(6'h04, d, resp);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL status_done got %h required 2", d); end
        core_busy = 1'b1;
        axi_read(6'h04, d, resp);
        core_busy = 1'b0;
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL status_busy got %h required 3", d); end
        // W1C of DONE lands on the same cycle as a fresh core_done
        @(negedge clk);
        awaddr = 6'h04; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        checks++;
        if (bvalid !== 1'b1) begin errors++; $display("FAIL w1c_race_bvalid got %b required 1", bvalid); end
        @(negedge clk);
        bready = 1'b0;
        axi_read(6'h04, d, resp);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL w1c_race_done got %h required 2", d); end
        axi_write(6'h04, 32'h2, 4'hF, resp);
        axi_read(6'h04, d, resp);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL w1c_clear got %h required 0", d); end
        core_busy = 1'b1;
        start_cnt = 0;
        axi_write(6'h00, 32'h1, 4'hF, resp);
        core_busy = 1'b0;
        checks++;
        if (start_cnt !== 1) begin errors++; $display("FAIL start_busy got %0d cycles required 1", start_cnt); end
    endtask

    task automatic test_decode_err();
        logic [1:0]  resp;
        logic [31:0] d;
        start_cnt = 0;
        axi_write(6'h20, 32'hDEADBEEF, 4'hF, resp);
        checks++;
        if (resp !== 2'b10) begin errors++; $display("FAIL oor_bresp got %b required 10", resp); end
        axi_read(6'h20, d, resp);
        checks++;
        if (d !== 32'h0 || resp !== 2'b10) begin
            errors++; $display("FAIL oor_read got %h/%b required 0/10", d, resp);
        end
        axi_read(6'h3C, d, resp);
        checks++;
        if (resp !== 2'b10) begin errors++; $display("FAIL oor_read_top got %b required 10", resp); end
        axi_read(6'h08, d, resp);
        checks++;
        if (d !== 32'h1 || start_cnt !== 0) begin
            errors++; $display("FAIL oor_no_change got reg2=%h starts=%0d required 1/0", d, start_cnt);
        end
    endtask

    task automatic test_soft_clr();
        logic [1:0]  resp;
        logic [31:0] d;
        @(negedge clk); core_done = 1'b1;
        @(negedge clk); core_done = 1'b0;
        axi_write(6'h00, 32'h2, 4'hF, resp);
        checks++;
        if (core_regs !== '0) begin errors++; $display("FAIL softclr_core_regs got %h required 0", core_regs); end
        axi_read(6'h1C, d, resp);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL softclr_reg7 got %h required 0", d); end
        axi_read(6'h04, d, resp);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL softclr_done got %h required 0", d); end
    endtask

    task automatic test_irq();
        logic [1:0]  resp;
        logic [31:0] d;
        axi_write(6'h00, 32'h4, 4'hF, resp);
        axi_read(6'h00, d, resp);
`ifdef CONV_COP_IRQ_EN
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL irq_en_read got %h required 4", d); end
        @(negedge clk); core_done = 1'b1;
        @(negedge clk); core_done = 1'b0;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b required 0", irq); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b required 1", irq); end
        axi_write(6'h04, 32'h2, 4'hF, resp);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b required 0", irq); end
`else
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL irq_en_absent got %h required 0", d); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [1:0]  resp;
        logic [31:0] d;
        axi_write(6'h08, 32'h77, 4'hF, resp);
        axi_write(6'h1C, 32'h99, 4'hF, resp);
        @(negedge clk);
        araddr = 6'h08; arvalid = 1'b1; rready = 1'b0;
        awaddr = 6'h18; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rvalid, bvalid} !== 2'b11) begin
            errors++; $display("FAIL midrst_pending got r/b=%b required 11", {rvalid, bvalid});
        end
        aresetn = 1'b0;
        @(negedge clk);
        checks++;
        if ({rvalid, bvalid, arready, awready} !== 4'b0) begin
            errors++;
            $display("FAIL midrst_valids got r/b/ar/aw=%b required 0000", {rvalid, bvalid, arready, awready});
        end
        aresetn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            axi_read(ADDR_W'(i * 4), d, resp);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL midrst_reg reg=%0d got %h required 0", i, d); end
        end
        checks++;
        if (core_regs !== '0) begin errors++; $display("FAIL midrst_core_regs got %h required 0", core_regs); end
    endtask

    initial begin
        test_reset();
        test_seq_rw();
        test_strobe();
        test_w_before_aw();
        test_ctrl_status();
        test_decode_err();
        test_soft_clr();
        test_irq();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
